// File: rtl/meter_pkg.sv
// Shared state encoding and channel tags for the stereo meter channel scheduler.
package meter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_ISSUE      = 2'd1;
  localparam state_t ST_WAIT_ARRAY = 2'd2;

  localparam logic CH_LEFT  = 1'b1;
  localparam logic CH_RIGHT = 1'b0;

endpackage

// File: rtl/meter_rr_arbiter.sv
// Two-requester round-robin arbiter; request/grant bits are indexed by channel tag.
module meter_rr_arbiter
  import meter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    // Contention goes to whichever channel was not served last.
    if (req_i[CH_LEFT] && req_i[CH_RIGHT]) begin
      gnt_o = 2'b00;
      if (last_i == CH_LEFT) gnt_o[CH_RIGHT] = 1'b1;
      else                   gnt_o[CH_LEFT]  = 1'b1;
    end
  end

endmodule

// File: rtl/menter_channel_scheduler.sv
// Serialises left/right level requests through one external position-to-array
// converter and publishes complete stereo frames to the display driver.
//   state         | meaning
//   ST_IDLE       | arbitrate and accept one level request
//   ST_ISSUE      | offer the registered request to the converter
//   ST_WAIT_ARRAY | wait for the converter's bar array
module menter_channel_scheduler
  import meter_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             l_valid,
  output logic             l_ready,
  input  logic [POS_W-1:0] l_position,
  input  logic             r_valid,
  output logic             r_ready,
  input  logic [POS_W-1:0] r_position,
  output logic             c_valid,
  input  logic             c_ready,
  output logic             c_is_left,
  output logic [POS_W-1:0] c_position,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_array,
  output logic             f_valid,
  input  logic             f_ready,
  output logic [WIDTH-1:0] f_left,
  output logic [WIDTH-1:0] f_right,
  output logic             overrun
);

  state_t           state_q, state_d;
  logic             last_q;
  logic             c_is_left_q;
  logic [POS_W-1:0] c_position_q;
  logic [WIDTH-1:0] buf_l_q, buf_r_q, f_left_q, f_right_q;
  logic             fresh_l_q, fresh_l_d, fresh_r_q, fresh_r_d;
  logic             f_valid_q, f_valid_d, overrun_q, overrun_d;
  logic [1:0]       gnt;
  logic             in_idle, accept, store, store_l, store_r, publish;

  meter_rr_arbiter u_arb (
    .req_i  ({l_valid, r_valid}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  assign in_idle = (state_q == ST_IDLE);
  assign l_ready = in_idle && gnt[CH_LEFT];
  assign r_ready = in_idle && gnt[CH_RIGHT];
  assign accept  = (l_valid && l_ready) || (r_valid && r_ready);
  assign c_valid = (state_q == ST_ISSUE);
  assign a_ready = (state_q == ST_WAIT_ARRAY);
  assign store   = a_valid && a_ready;
  assign store_l = store && (c_is_left_q == CH_LEFT);
  assign store_r = store && (c_is_left_q == CH_RIGHT);
  // Publish reads the registered working buffers, so a coinciding store lands in the next frame.
  assign publish = fresh_l_q && fresh_r_q && (!f_valid_q || f_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (accept)  state_d = ST_ISSUE;
      ST_ISSUE:      if (c_ready) state_d = ST_WAIT_ARRAY;
      ST_WAIT_ARRAY: if (a_valid) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fresh_l_d = fresh_l_q && !publish;
    fresh_r_d = fresh_r_q && !publish;
    if (store_l) fresh_l_d = 1'b1;
    if (store_r) fresh_r_d = 1'b1;
    f_valid_d = publish || (f_valid_q && !f_ready);
    // Only a write that destroys an unpublishable complete frame counts as an overrun.
    overrun_d = overrun_q || (store && fresh_l_q && fresh_r_q && !publish);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_q       <= CH_RIGHT;
      c_is_left_q  <= 1'b0;
      c_position_q <= '0;
      buf_l_q      <= '0;
      buf_r_q      <= '0;
      f_left_q     <= '0;
      f_right_q    <= '0;
      fresh_l_q    <= 1'b0;
      fresh_r_q    <= 1'b0;
      f_valid_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fresh_l_q <= fresh_l_d;
      fresh_r_q <= fresh_r_d;
      f_valid_q <= f_valid_d;
      overrun_q <= overrun_d;
      if (accept) begin
        last_q       <= gnt[CH_LEFT];
        c_is_left_q  <= gnt[CH_LEFT];
        c_position_q <= gnt[CH_LEFT] ? l_position : r_position;
      end
      if (store_l) buf_l_q <= a_array;
      if (store_r) buf_r_q <= a_array;
      if (publish) begin
        f_left_q  <= buf_l_q;
        f_right_q <= buf_r_q;
      end
    end
  end

  assign c_is_left  = c_is_left_q;
  assign c_position = c_position_q;
  assign f_valid    = f_valid_q;
  assign f_left     = f_left_q;
  assign f_right    = f_right_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/menter_channel_scheduler.md
MENTER_CHANNEL_SCHEDULER -- requirements
Module: meter_channel_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 32: segment count per channel bar.
REQ-002 SHALL have localparam POS_W = $clog2(WIDTH): position width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port l_valid / l_ready / l_position  in / out / in  1 / 1 / POS_W  left level request.
REQ-006 SHALL have port r_valid / r_ready / r_position  in / out / in  1 / 1 / POS_W  right level request.
REQ-007 SHALL have port c_valid / c_ready / c_is_left / c_position  out / in / out / out  1 / 1 / 1 / POS_W  to position-to-array converter.
REQ-008 SHALL have port a_valid / a_ready / a_array  in / out / in  1 / 1 / WIDTH  bar array returned by converter.
REQ-009 SHALL have port f_valid / f_ready / f_left / f_right  out / in / out / out  1 / 1 / WIDTH / WIDTH  stereo frame to display driver.
REQ-010 SHALL have port overrun  output  1  sticky flag: a complete frame was overwritten before publication.

Function
REQ-011 SHALL run FSM states IDLE, ISSUE, WAIT_ARRAY; exactly one converter transaction outstanding.
REQ-012 SHALL, in IDLE, drive l_ready/r_ready combinationally: high only for the granted channel; both low outside IDLE.
REQ-013 SHALL grant round-robin: both valid -> channel not served last; one valid -> that channel; last-served resets to right, so left wins first.
REQ-014 SHALL, on granted valid&&ready, register position and tag (is_left), update last-served, go to ISSUE next cycle.
REQ-015 SHALL hold c_valid=1 with stable c_is_left/c_position throughout ISSUE; on c_valid&&c_ready go to WAIT_ARRAY.
REQ-016 SHALL assert a_ready only in WAIT_ARRAY; on a_valid&&a_ready write a_array into working buffer of tagged channel, set that channel's fresh bit, return to IDLE.
REQ-017 SHALL ignore a_valid outside WAIT_ARRAY (no state change).
REQ-018 SHALL publish when both fresh bits set and (!f_valid || f_ready): copy working buffers to f_left/f_right, set f_valid, clear both fresh bits, same edge.
REQ-019 SHALL clear f_valid on f_valid&&f_ready unless a publish occurs on that edge (publish wins, f_valid stays 1).
REQ-020 SHALL keep f_left/f_right stable while f_valid=1 and f_ready=0.
REQ-021 SHALL set overrun when a channel write targets a fresh bit already set while the other fresh bit is also set; overrun clears only on reset.
REQ-022 SHALL, when array store and publish coincide, publish old working values and leave the new write's fresh bit set.
REQ-023 SHALL achieve minimum request-accept to f_valid latency of 3 cycles plus converter latency, for the second channel of a frame.

Reset
REQ-024 SHALL, on reset_n low, asynchronously force: state IDLE, c_valid 0, a_ready 0, f_valid 0, f_left/f_right 0, working buffers 0, fresh bits 0, overrun 0, last-served right, c_is_left 0, c_position 0.
REQ-025 SHALL, on reset mid-transaction, abandon it; a late a_valid after reset is ignored per REQ-017.

Structure
REQ-026 SHALL place FSM state enum and channel tag constants (CH_LEFT=1, CH_RIGHT=0) in shared package meter_pkg.
REQ-027 SHALL implement grant logic as sub-module meter_rr_arbiter (2 requesters, last-served input, one-hot grant).
REQ-028 SHALL NOT instantiate the converter; connection at top level.

Verification
REQ-029 SHALL test: l_valid, r_valid both high from reset, converter immediately ready -> left served first, then right; one frame f_valid with converter arrays.
REQ-030 SHALL test: only l_valid pulses 3 times -> left served each time, f_valid stays 0, overrun stays 0 (no right fresh).
REQ-031 SHALL test: c_ready held low 10 cycles in ISSUE -> c_valid, c_position=5, c_is_left=1 held stable, l_ready/r_ready low.
REQ-032 SHALL test: f_ready low, two full frames (0x0000_000F/0x0000_00FF then 0x0000_0FFF/0x0000_FFFF) -> f_left=0x0000_000F held; third left write sets overrun=1.
REQ-033 SHALL test: reset_n low during WAIT_ARRAY, then a_valid pulse -> all outputs at reset values, no buffer write.
REQ-034 SHALL test: f_ready=1 on cycle both halves become fresh, with frame already valid -> f_valid remains 1, new data appears next edge.
